// File: rtl/tone_pkg.sv
// tone_pkg: shared widths, FSM state encoding and the octave-4 half-period
// table for the tone player slice.
//   OCTAVE_BITS / NOTE_BITS / LENGTH_BITS : command field widths
//   FULL_NOTE_BITS                        : {octave, note} export width
//   HP_BITS                               : half-period counter width (octave 1 needs 21)
//   tone_state_e                          : IDLE / PLAY / GAP
//   HALF_PERIOD_O4                        : octave-4 half periods, index 0 = do
package tone_pkg;

  localparam int OCTAVE_BITS    = 3;
  localparam int NOTE_BITS      = 3;
  localparam int LENGTH_BITS    = 3;
  localparam int FULL_NOTE_BITS = OCTAVE_BITS + NOTE_BITS;
  localparam int HP_BITS        = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } tone_state_e;

  // Half periods in clock cycles at 100 MHz, do..si, octave 4.
  localparam logic [6:0][HP_BITS-1:0] HALF_PERIOD_O4 = {
    21'd101239,  // si
    21'd113636,  // la
    21'd127551,  // so
    21'd143173,  // fa
    21'd151686,  // mi
    21'd170262,  // re
    21'd191113   // do
  };

endpackage

// File: rtl/tone_if.sv
// tone_if: command/status bundle between the mode controller and tone_player.
//   en, start, octave, note, length : command side (master drives)
//   full_note, buzzer, over         : status side (slave drives)
// Handshake: over is the ready signal and start is a one-cycle valid; a
// command transfers on a rising edge where start=1, en=1 and the player is
// IDLE (over=1). A start seen while over=0, or in the same cycle as en=0, is
// dropped, and the command fields are don't-care after the transfer edge.
interface tone_if;
  import tone_pkg::*;

  logic                      en;
  logic                      start;
  logic [OCTAVE_BITS-1:0]    octave;
  logic [NOTE_BITS-1:0]      note;
  logic [LENGTH_BITS-1:0]    length;
  logic [FULL_NOTE_BITS-1:0] full_note;
  logic                      buzzer;
  logic                      over;

  modport master (
    output en, start, octave, note, length,
    input  full_note, buzzer, over
  );

  modport slave (
    input  en, start, octave, note, length,
    output full_note, buzzer, over
  );

endinterface

// File: rtl/tone_period_lut.sv
// tone_period_lut: combinational half-period lookup.
//   octave      in  octave 1..7 (4 = middle); 0 is a rest, result unused
//   note        in  0 = rest (result unused), 1..7 = do..si
//   half_period out HP_BITS half period in cycles, shifted right by HP_SHIFT
//                   and never less than 1
module tone_period_lut
  import tone_pkg::*;
#(
  parameter int HP_SHIFT = 0
) (
  input  logic [OCTAVE_BITS-1:0] octave,
  input  logic [NOTE_BITS-1:0]   note,
  output logic [HP_BITS-1:0]     half_period
);

  logic [NOTE_BITS-1:0] idx;
  logic [HP_BITS-1:0]   base;
  logic [HP_BITS-1:0]   scaled;
  logic [HP_BITS-1:0]   shifted;

  always_comb begin
    idx     = note - 3'd1;
    base    = (note == '0) ? HP_BITS'(1) : HALF_PERIOD_O4[idx];
    // Each octave up halves the period; each octave down doubles it.
    if (octave > 3'd4) begin
      scaled = base >> (octave - 3'd4);
    end else begin
      scaled = base << (3'd4 - octave);
    end
    shifted     = scaled >> HP_SHIFT;
    // A zero half period would never wrap the counter, so clamp to 1.
    half_period = (shifted == '0) ? HP_BITS'(1) : shifted;
  end

endmodule

// File: rtl/tone_player.sv
// tone_player: plays one latched note command as a square wave on buzzer for
// (length+1)*UNIT_CYCLES cycles, the last GAP_CYCLES of which are silent.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (slave) : en/start/octave/note/length in; full_note/buzzer/over out
//   state_dbg   : current FSM state for observation
module tone_player
  import tone_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int HP_SHIFT    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  tone_if.slave       bus,
  output tone_state_e state_dbg
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_PLAY = PLAY;
  localparam logic [1:0] S_GAP  = GAP;

  logic [1:0]             state;
  logic [OCTAVE_BITS-1:0] octave_q;
  logic [NOTE_BITS-1:0]   note_q;
  logic [LENGTH_BITS-1:0] length_q;
  logic [31:0]            dur_cnt;
  logic [31:0]            dur_total;
  logic [31:0]            play_last;
  logic [HP_BITS-1:0]     half_cnt;
  logic [HP_BITS-1:0]     half_period;
  logic                   buzzer_q;
  logic                   is_rest;

  tone_period_lut #(.HP_SHIFT(HP_SHIFT)) u_lut (
    .octave      (octave_q),
    .note        (note_q),
    .half_period (half_period)
  );

  // 32 bits covers 8 * 12.5M with room to spare.
  assign dur_total = (32'(length_q) + 32'd1) * 32'(UNIT_CYCLES);
  assign play_last = dur_total - 32'(GAP_CYCLES) - 32'd1;
  assign is_rest   = (note_q == '0) || (octave_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      octave_q <= '0;
      note_q   <= '0;
      length_q <= '0;
      dur_cnt  <= '0;
      half_cnt <= '0;
      buzzer_q <= 1'b0;
    end else if (!bus.en) begin
      // Abort: back to IDLE, but keep the latched note visible.
      state    <= S_IDLE;
      dur_cnt  <= '0;
      half_cnt <= '0;
      buzzer_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_PLAY;
            octave_q <= bus.octave;
            note_q   <= bus.note;
            length_q <= bus.length;
            dur_cnt  <= '0;
            half_cnt <= '0;
            buzzer_q <= 1'b0;
          end
        end
        S_PLAY: begin
          dur_cnt <= dur_cnt + 32'd1;
          if (dur_cnt == play_last) begin
            // Entering the silent tail takes priority over a toggle.
            state    <= S_GAP;
            half_cnt <= '0;
            buzzer_q <= 1'b0;
          end else if (half_cnt == half_period - HP_BITS'(1)) begin
            half_cnt <= '0;
            if (!is_rest) buzzer_q <= ~buzzer_q;
          end else begin
            half_cnt <= half_cnt + HP_BITS'(1);
          end
        end
        S_GAP: begin
          half_cnt <= '0;
          buzzer_q <= 1'b0;
          if (dur_cnt == dur_total - 32'd1) begin
            state   <= S_IDLE;
            dur_cnt <= '0;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          dur_cnt  <= '0;
          half_cnt <= '0;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.over      = (state == S_IDLE);
  assign bus.buzzer    = buzzer_q;
  assign bus.full_note = {octave_q, note_q};
  assign state_dbg     = tone_state_e'(state);

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed, table-driven bench for tone_player with
// UNIT_CYCLES=200, GAP_CYCLES=20; one instance at HP_SHIFT=10 and one at
// HP_SHIFT=16 for the one-cycle half-period case.
module tb_tone_player;
  import tone_pkg::*;

  localparam int UNIT = 200;
  localparam int GAPC = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_if bus();
  tone_if bus16();
  tone_state_e state_dbg;
  tone_state_e state_dbg16;

  tone_player #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAPC), .HP_SHIFT(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  tone_player #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAPC), .HP_SHIFT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .state_dbg(state_dbg16)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic drive_start(input logic [2:0] o, input logic [2:0] n, input logic [2:0] l);
    bus.octave = o;
    bus.note   = n;
    bus.length = l;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    // Fields are don't-care after acceptance; scramble them.
    bus.octave = 3'($urandom_range(0, 7));
    bus.note   = 3'($urandom_range(0, 7));
    bus.length = 3'($urandom_range(0, 7));
  endtask

  // Samples every negedge from j=0 (first sample after acceptance) until over
  // rises; toggles are only recorded before the expected silent tail.
  task automatic observe(input int exp_dur, input int mid_j, output int low_cnt,
                         output int first_t, output int second_t, output int gap_hi);
    logic prev;
    int j;
    prev = 1'b0; j = 0; first_t = 0; second_t = 0; gap_hi = 0;
    while (bus.over == 1'b0 && j < 4000) begin
      if (bus.buzzer !== prev && j < exp_dur - GAPC) begin
        if (first_t == 0) first_t = j;
        else if (second_t == 0) second_t = j;
      end
      if (j >= exp_dur - GAPC && bus.buzzer !== 1'b0) gap_hi = 1;
      if (mid_j != 0 && j == mid_j) begin
        bus.octave = 3'd7; bus.note = 3'd1; bus.length = 3'd0; bus.start = 1'b1;
      end
      if (mid_j != 0 && j == mid_j + 1) bus.start = 1'b0;
      prev = bus.buzzer;
      j++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    low_cnt = j;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0] oct;
    logic [2:0] note;
    logic [2:0] len;
    int         mid_j;
    logic [5:0] exp_fn;
    int         exp_dur;
    int         exp_first;
    int         exp_ivl;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, first_t, second_t, gap_hi, ivl, j;
    logic [5:0] fn_exp;

    vecs[0] = '{3'd4, 3'd6, 3'd0, 0,   6'd38, 200, 110, 0};    // la4
    vecs[1] = '{3'd5, 3'd1, 3'd3, 0,   6'd41, 800, 93,  93};   // do5
    vecs[2] = '{3'd2, 3'd1, 3'd3, 0,   6'd17, 800, 746, 0};    // do2
    vecs[3] = '{3'd4, 3'd0, 3'd1, 100, 6'd32, 400, 0,   0};    // rest + mid start
    vecs[4] = '{3'd4, 3'd3, 3'd1, 0,   6'd35, 400, 148, 148};  // mi4
    vecs[5] = '{3'd0, 3'd3, 3'd0, 0,   6'd3,  200, 0,   0};    // octave-0 rest
    vecs[6] = '{3'd6, 3'd7, 3'd2, 0,   6'd55, 600, 24,  24};   // si6

    // Reset held with start=1 and a live command on the inputs.
    bus.en = 1'b1; bus.start = 1'b1; bus.octave = 3'd4; bus.note = 3'd6; bus.length = 3'd0;
    bus16.en = 1'b1; bus16.start = 1'b0; bus16.octave = 3'd0; bus16.note = 3'd0; bus16.length = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_buzzer", int'(bus.buzzer), 0);
      check("reset_over", int'(bus.over), 1);
      check("reset_full_note", int'(bus.full_note), 0);
    end
    rst_n = 1'b1; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_over", int'(bus.over), 1);
    check("post_reset_full_note", int'(bus.full_note), 0);
    check("post_reset_state", int'(state_dbg), int'(IDLE));

    // Table-driven notes.
    for (int i = 0; i < 7; i++) begin
      drive_start(vecs[i].oct, vecs[i].note, vecs[i].len);
      exp_q.push_back(vecs[i].exp_fn);
      check($sformatf("v%0d_over_at_accept", i), int'(bus.over), 0);
      fn_exp = exp_q.pop_front();
      check($sformatf("v%0d_full_note", i), int'(bus.full_note), int'(fn_exp));
      observe(vecs[i].exp_dur, vecs[i].mid_j, low, first_t, second_t, gap_hi);
      ivl = (second_t != 0) ? second_t - first_t : 0;
      check($sformatf("v%0d_over_low_cycles", i), low, vecs[i].exp_dur);
      check($sformatf("v%0d_first_toggle", i), first_t, vecs[i].exp_first);
      check($sformatf("v%0d_toggle_interval", i), ivl, vecs[i].exp_ivl);
      check($sformatf("v%0d_gap_silent", i), gap_hi, 0);
      check($sformatf("v%0d_full_note_end", i), int'(bus.full_note), int'(vecs[i].exp_fn));
      @(negedge clk);
    end

    // Abort 50 cycles into do6 length 7, with a start in the abort cycle.
    drive_start(3'd6, 3'd1, 3'd7);
    repeat (50) @(negedge clk);
    check("abort_pre_buzzer", int'(bus.buzzer), 1);
    bus.en = 1'b0; bus.start = 1'b1; bus.octave = 3'd1; bus.note = 3'd2; bus.length = 3'd0;
    @(negedge clk);
    check("abort_buzzer", int'(bus.buzzer), 0);
    check("abort_over", int'(bus.over), 1);
    check("abort_full_note_held", int'(bus.full_note), 49);
    bus.en = 1'b1;
    drive_start(3'd4, 3'd6, 3'd0);
    check("after_abort_over", int'(bus.over), 0);
    check("after_abort_full_note", int'(bus.full_note), 38);
    observe(200, 0, low, first_t, second_t, gap_hi);
    check("after_abort_low_cycles", low, 200);
    check("after_abort_first_toggle", first_t, 110);

    // Reset in the middle of PLAY while the buzzer is high.
    @(negedge clk);
    drive_start(3'd4, 3'd6, 3'd0);
    repeat (130) @(negedge clk);
    check("midreset_pre_buzzer", int'(bus.buzzer), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_buzzer", int'(bus.buzzer), 0);
    check("midreset_over", int'(bus.over), 1);
    check("midreset_full_note", int'(bus.full_note), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: start on the cycle over rises is dropped, next one taken.
    drive_start(3'd4, 3'd6, 3'd0);
    repeat (199) @(negedge clk);
    check("b2b_over_before", int'(bus.over), 0);
    check("b2b_state_gap", int'(state_dbg), int'(GAP));
    bus.octave = 3'd5; bus.note = 3'd1; bus.length = 3'd0; bus.start = 1'b1;
    @(negedge clk);
    check("b2b_over_rise", int'(bus.over), 1);
    check("b2b_not_latched", int'(bus.full_note), 38);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accept_over", int'(bus.over), 0);
    check("b2b_accept_full_note", int'(bus.full_note), 41);
    observe(200, 0, low, first_t, second_t, gap_hi);
    check("b2b_low_cycles", low, 200);
    check("b2b_first_toggle", first_t, 93);

    // si7 at HP_SHIFT=16: half period floors at 1, toggle every cycle.
    bus16.octave = 3'd7; bus16.note = 3'd7; bus16.length = 3'd0; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    check("hp1_full_note", int'(bus16.full_note), 63);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("hp1_buzzer_j%0d", k), int'(bus16.buzzer), k % 2);
    end
    j = 6;
    while (bus16.over == 1'b0 && j < 1000) begin
      @(negedge clk);
      j++;
    end
    check("hp1_low_cycles", j, 200);
    check("hp1_state_idle", int'(state_dbg16), int'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Downstream playback stage of the study/free-play datapath.
- Consumes one note command (octave, note, length), plus a start pulse from the hit/pulse logic.
- Drives the buzzer with a square wave for the commanded duration, then raises `over` so the mode controller can advance or re-arm.
- Exports the latched `full_note` for the song/record lookups.

Parameters:
- UNIT_CYCLES, 12_500_000, clock cycles per length unit (1/8 s at 100 MHz).
- GAP_CYCLES, 1_000_000, silent articulation tail at the end of every note; must be < UNIT_CYCLES.
- HP_SHIFT, 0, right-shift applied to every half-period (simulation speed-up only).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  level enable; low forces IDLE.
- start  in  1  one-cycle request to play the command on octave/note/length.
- octave  in  OCTAVE_BITS(3)  1..7, 4 = middle; 0 = rest.
- note  in  NOTE_BITS(3)  0 = rest, 1..7 = do..si.
- length  in  LENGTH_BITS(3)  duration code; duration = (length+1)*UNIT_CYCLES.
- full_note  out  FULL_NOTE_BITS(6)  {octave_q, note_q} of the note being/last played.
- buzzer  out  1  square-wave output.
- over  out  1  high when IDLE (ready / finished).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, buzzer=0, over=1, full_note=0.
  - All counters and latches cleared.
- States and transitions:
  - IDLE → PLAY on start=1 & en=1; start is ignored in every other state.
  - PLAY → GAP when dur_cnt reaches dur_total-GAP_CYCLES-1.
  - GAP → IDLE when dur_cnt reaches dur_total-1.
  - Any state → IDLE when en=0: buzzer=0 and over=1 at the next edge. full_note holds its value.
- Acceptance at edge t (start sampled while IDLE):
  - octave_q/note_q/length_q latch the inputs.
  - dur_cnt=0, half_cnt=0, buzzer=0.
  - Outputs change at edge t: over=0 and full_note updated.
  - Inputs are don't-care after acceptance.
- Duration:
  - dur_total = (length_q+1)*UNIT_CYCLES, computed with width ≥27 bits, no overflow.
  - over returns to 1 exactly dur_total cycles after the acceptance edge.
- Tone generation in PLAY:
  - half_period = LUT(note_q) adjusted for octave_q, then >>HP_SHIFT, then floored at 1.
  - Octave adjustment: octave_q>4 → LUT>>(octave_q-4); octave_q<4 → LUT<<(4-octave_q).
  - half_cnt counts 0..half_period-1. On wrap, buzzer toggles and half_cnt returns to 0.
  - First toggle occurs half_period cycles after acceptance.
- GAP: buzzer forced 0; half_cnt held at 0.
- Rests (note_q=0 or octave_q=0): full duration runs, buzzer held 0 throughout, over timing unchanged.
- Octave-4 half-period LUT, in cycles:
  - do 191113, re 170262, mi 151686, fa 143173, so 127551, la 113636, si 101239.
  - Octave-1 values need 21-bit half_cnt.
- Simultaneous events:
  - start in the same cycle over rises is ignored, because the state is still GAP.
  - en=0 together with start: the abort wins, nothing is latched.
  - Reset during PLAY returns all outputs to reset values at that edge.

Decomposition:
- Shared package tone_pkg holds:
  - OCTAVE_BITS, NOTE_BITS, LENGTH_BITS, FULL_NOTE_BITS.
  - The state enum IDLE/PLAY/GAP.
  - The 7-entry octave-4 half-period table.
- One sub-module, tone_period_lut:
  - Combinational {octave, note, HP_SHIFT} → 21-bit half_period.
  - Includes the shift and floor-at-1.
- The FSM and counters stay in tone_player.

Test Plan:
All scenarios use UNIT_CYCLES=200, GAP_CYCLES=20, HP_SHIFT=10 unless noted.

1. Reset: hold rst_n=0 for 3 cycles with start=1 → buzzer=0, over=1, full_note=0 throughout. Release: still IDLE, nothing latched.
2. la4 (octave=4, note=6, length=0), start at edge t:
   - over=0 from t to t+199, over=1 at t+200.
   - half_period=110, so buzzer toggles at t+110 and t+220 is never reached.
   - buzzer=0 during the last 20 cycles; full_note=6'b100110.
3. Octave scaling: do5 (octave 5, note 1) gives half_period 93; do2 (octave 2, note 1) gives 746 → measured toggle intervals match. With length=3, over stays low for exactly 800 cycles.
4. Rest: note=0, length=1 → buzzer constantly 0, over low for 400 cycles. Second start mid-note is ignored, with no change to full_note or timing.
5. Abort: en dropped 50 cycles into a length=7 note → next edge buzzer=0, over=1. A start on the following cycle with en=1 is accepted normally.
6. Back-to-back: start asserted on the cycle over rises is ignored; start one cycle later is accepted. Octave 7 / si with HP_SHIFT=16 gives half_period 1 → buzzer toggles every cycle.
